// File: rtl/renkon_pkg.sv
// Shared renkon definitions: window-controller FSM states and default geometry.
package renkon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int FSIZE_DEF  = 5;
  localparam int LWIDTH_DEF = 6;

endpackage

// File: rtl/renkon_wrap_counter.sv
// Up-counter that runs 0..limit and wraps, with a one-cycle wrap strobe and a
// synchronous clear; used for the column counter and the line-buffer ring.
module renkon_wrap_counter
  import renkon_pkg::*;
#(
  parameter int WIDTH = LWIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap  = en && (count_q == limit);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/renkon_ctrl_window.sv
// Sliding-window controller: streams a square image into FSIZE line buffers and
// flags each full FSIZE x FSIZE window. Define RENKON_CTRL_WINDOW_STRIDE2_EN for stride-2 windows.
//
// state   | meaning
// IDLE    | waiting for start; counters hold, no pixels accepted
// PRELOAD | filling the first FSIZE-1 lines, no window possible yet
// STREAM  | remaining lines; windows produced, ends once last window retires
// DONE    | one-cycle done pulse, then back to IDLE
module renkon_ctrl_window
  import renkon_pkg::*;
#(
  parameter int  FSIZE  = FSIZE_DEF,
  parameter int  LWIDTH = LWIDTH_DEF,
  localparam int SELW   = $clog2(FSIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LWIDTH-1:0] img_size,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              buf_we,
  output logic [SELW-1:0]   buf_sel,
  output logic [LWIDTH-1:0] buf_addr,
  output logic [SELW-1:0]   buf_top,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [LWIDTH-1:0] out_row,
  output logic [LWIDTH-1:0] out_col,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LWIDTH-1:0] FS_L     = LWIDTH'(FSIZE);
  localparam logic [LWIDTH-1:0] EDGE     = LWIDTH'(FSIZE - 1);
  localparam logic [LWIDTH-1:0] PRE_LAST = LWIDTH'(FSIZE - 2);
  localparam logic [SELW-1:0]   SEL_MAX  = SELW'(FSIZE - 1);

  state_e            state_q, state_d;
  logic [LWIDTH-1:0] img_size_q, img_size_d;
  logic [LWIDTH-1:0] row_q, row_d;
  logic [LWIDTH-1:0] out_row_q, out_row_d;
  logic [LWIDTH-1:0] out_col_q, out_col_d;
  logic              win_valid_q, win_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last_q, last_d;

  logic              accept;
  logic              frame_start;
  logic [LWIDTH-1:0] col;
  logic              col_wrap;
  logic [SELW-1:0]   sel;
  logic              sel_wrap_unused;
  logic [LWIDTH-1:0] dr;
  logic [LWIDTH-1:0] dc;
  logic              win_pos;
  logic              win_set;
  logic              last_pix;

  // Once the final pixel is in, further beats would corrupt the counters.
  assign in_ready    = busy_q && (state_q != ST_DONE) && !last_q && !(win_valid_q && !win_ready);
  assign accept      = in_valid && in_ready;
  assign frame_start = (state_q == ST_IDLE) && start && (img_size >= FS_L);

  renkon_wrap_counter #(.WIDTH(LWIDTH)) u_col_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_start),
    .en    (accept),
    .limit (img_size_q - LWIDTH'(1)),
    .count (col),
    .wrap  (col_wrap)
  );

  renkon_wrap_counter #(.WIDTH(SELW)) u_sel_ring (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_start),
    .en    (col_wrap),
    .limit (SEL_MAX),
    .count (sel),
    .wrap  (sel_wrap_unused)
  );

  assign buf_we   = accept;
  assign buf_sel  = sel;
  assign buf_addr = col;
  assign buf_top  = (row_q >= EDGE) ? ((sel == SEL_MAX) ? '0 : sel + SELW'(1)) : '0;

  assign dr       = row_q - EDGE;
  assign dc       = col - EDGE;
  assign win_pos  = accept && (row_q >= EDGE) && (col >= EDGE);
  assign last_pix = col_wrap && (row_q == img_size_q - LWIDTH'(1));

`ifdef RENKON_CTRL_WINDOW_STRIDE2_EN
  assign win_set = win_pos && !dr[0] && !dc[0];
`else
  assign win_set = win_pos;
`endif

  always_comb begin
    state_d     = state_q;
    img_size_d  = img_size_q;
    row_d       = row_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    win_valid_d = win_valid_q;
    err_d       = err_q;
    last_d      = last_q;

    // Retire and register in the same cycle, so back-to-back windows have no bubble.
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end
    if (win_set) begin
      win_valid_d = 1'b1;
`ifdef RENKON_CTRL_WINDOW_STRIDE2_EN
      out_row_d   = {1'b0, dr[LWIDTH-1:1]};
      out_col_d   = {1'b0, dc[LWIDTH-1:1]};
`else
      out_row_d   = dr;
      out_col_d   = dc;
`endif
    end
    if (col_wrap) begin
      row_d = row_q + LWIDTH'(1);
    end
    if (last_pix) begin
      last_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (img_size >= FS_L) begin
            img_size_d = img_size;
            row_d      = '0;
            last_d     = 1'b0;
            err_d      = 1'b0;
            state_d    = ST_PRELOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRELOAD: begin
        if (col_wrap && (row_q == PRE_LAST)) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_q && (!win_valid_q || win_ready)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      img_size_q  <= '0;
      row_q       <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_size_q  <= img_size_d;
      row_q       <= row_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_q      <= last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_renkon_ctrl_window.sv
// Bench for renkon_ctrl_window: frame-level model (pixel index, pending window)
// checked every cycle, plus literal expectations for the key frame scenarios.
module tb_renkon_ctrl_window;

  localparam int F  = 5;
  localparam int LW = 6;
  localparam int SW = 3;
`ifdef RENKON_CTRL_WINDOW_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
  localparam int WIN8    = 4;
`else
  localparam bit STRIDE2 = 1'b0;
  localparam int WIN8    = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] img_size;
  logic          in_valid;
  logic          in_ready;
  logic          buf_we;
  logic [SW-1:0] buf_sel;
  logic [LW-1:0] buf_addr;
  logic [SW-1:0] buf_top;
  logic          win_valid;
  logic          win_ready;
  logic [LW-1:0] out_row;
  logic [LW-1:0] out_col;
  logic          busy;
  logic          done;
  logic          err;

  renkon_ctrl_window dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_size  (img_size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .buf_we    (buf_we),
    .buf_sel   (buf_sel),
    .buf_addr  (buf_addr),
    .buf_top   (buf_top),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // model: phase 0 idle, 1 running, 2 done; m_n = pixels accepted this frame
  int m_phase, m_n, m_img, m_err, m_wv, m_or, m_oc;

  int cyc, pix_seen, wins_seen, first_n, last_win_cyc, done_cyc, top_row7;
  int sel_log[$];
  int win_r[$];
  int win_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_in_ready();
    return (m_phase == 1 && m_n < m_img * m_img && !(m_wv != 0 && !win_ready)) ? 1 : 0;
  endfunction

  task automatic reset_model();
    m_phase = 0; m_n = 0; m_img = 0; m_err = 0; m_wv = 0; m_or = 0; m_oc = 0;
  endtask

  task automatic clear_track();
    cyc = 0; pix_seen = 0; wins_seen = 0; first_n = -1; last_win_cyc = -1;
    done_cyc = -1; top_row7 = -1;
    sel_log.delete(); win_r.delete(); win_c.delete();
  endtask

  task automatic check();
    int r, c, esel, etop, erdy;
    erdy = exp_in_ready();
    r    = (m_img == 0) ? 0 : m_n / m_img;
    c    = (m_img == 0) ? 0 : m_n % m_img;
    esel = r % F;
    etop = (r >= F - 1) ? (esel + 1) % F : 0;
    chk("in_ready", in_ready, erdy);
    chk("buf_we", buf_we, (in_valid && erdy != 0) ? 1 : 0);
    chk("buf_sel", buf_sel, esel);
    chk("buf_addr", buf_addr, c);
    chk("buf_top", buf_top, etop);
    chk("win_valid", win_valid, m_wv);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("done", done, (m_phase == 2) ? 1 : 0);
    chk("err", err, m_err);
    if (m_wv != 0) begin
      chk("out_row", out_row, m_or);
      chk("out_col", out_col, m_oc);
    end
    if (buf_we) begin
      pix_seen++;
      if (buf_addr == 0) sel_log.push_back(int'(buf_sel));
      if (r == 7) top_row7 = int'(buf_top);
    end
    if (win_valid && first_n < 0) first_n = m_n;
    if (win_valid && win_ready) begin
      wins_seen++;
      last_win_cyc = cyc;
      win_r.push_back(int'(out_row));
      win_c.push_back(int'(out_col));
    end
    if (done) done_cyc = cyc;
    cyc++;
  endtask

  task automatic model_update();
    int acc, r, c, fin;
    acc = (in_valid && exp_in_ready() != 0) ? 1 : 0;
    case (m_phase)
      0: begin
        if (start) begin
          if (int'(img_size) >= F) begin
            m_img = int'(img_size); m_n = 0; m_err = 0; m_phase = 1;
          end else begin
            m_err = 1;
          end
        end
      end
      1: begin
        fin = (m_n == m_img * m_img && (m_wv == 0 || win_ready)) ? 1 : 0;
        if (m_wv != 0 && win_ready) m_wv = 0;
        if (acc != 0) begin
          r = m_n / m_img - (F - 1);
          c = m_n % m_img - (F - 1);
          m_n++;
          if (r >= 0 && c >= 0) begin
            if (!STRIDE2) begin
              m_wv = 1; m_or = r; m_oc = c;
            end else if (r % 2 == 0 && c % 2 == 0) begin
              m_wv = 1; m_or = r / 2; m_oc = c / 2;
            end
          end
        end
        if (fin != 0) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    #1;
    check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // gaps: 1 = periodic in_valid/win_ready bubbles; abort_pix > 0 stops early
  task automatic run_frame(input int sz, input int stall, input int gaps, input int abort_pix);
    int stall_left;
    bit timed_out;
    clear_track();
    stall_left = stall;
    timed_out  = 1'b1;
    start = 1'b1; img_size = LW'(sz); in_valid = 1'b1; win_ready = 1'b1;
    step();
    for (int k = 0; k < 3000; k++) begin
      start     = (k == 10);
      img_size  = (k == 10) ? LW'(12) : LW'(sz);
      in_valid  = (gaps != 0) ? (k % 3 != 2) : 1'b1;
      win_ready = (gaps != 0) ? (k % 4 != 3) : 1'b1;
      if (stall_left > 0 && m_wv != 0) begin
        win_ready = 1'b0;
        stall_left--;
        #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_win_valid", win_valid, 1);
        chk("stall_out_row", out_row, 0);
        chk("stall_out_col", out_col, 0);
      end
      step();
      if (abort_pix > 0 && pix_seen >= abort_pix) begin
        timed_out = 1'b0;
        break;
      end
      if (done_cyc >= 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
    if (timed_out) begin
      vecs++; miss++;
      $display("FAIL frame_timeout: size %0d, done never seen after %0d cycles", sz, cyc);
    end
  endtask

  initial begin
    int exp_sel[8];
    exp_sel = '{0, 1, 2, 3, 4, 0, 1, 2};
    rst = 1'b1; start = 1'b0; img_size = '0; in_valid = 1'b0; win_ready = 1'b1;
    reset_model();
    clear_track();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_buf_sel", buf_sel, 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // basic frame: 8x8, no back-pressure
    run_frame(8, 0, 0, 0);
    chk("first_win_after_pixels", first_n, 37);
    chk("frame8_pixels", pix_seen, 64);
    chk("frame8_windows", wins_seen, WIN8);
    chk("sel_log_len", sel_log.size(), 8);
    for (int i = 0; i < 8 && i < sel_log.size(); i++) chk("sel_seq", sel_log[i], exp_sel[i]);
    chk("buf_top_row7", top_row7, 3);
`ifdef RENKON_CTRL_WINDOW_STRIDE2_EN
    chk("stride_win_cnt", win_r.size(), 4);
    if (win_r.size() == 4) begin
      chk("stride_w0_r", win_r[0], 0); chk("stride_w0_c", win_c[0], 0);
      chk("stride_w1_r", win_r[1], 0); chk("stride_w1_c", win_c[1], 1);
      chk("stride_w2_r", win_r[2], 1); chk("stride_w2_c", win_c[2], 0);
      chk("stride_w3_r", win_r[3], 1); chk("stride_w3_c", win_c[3], 1);
    end
`else
    chk("done_after_last_win", done_cyc - last_win_cyc, 1);
    if (win_r.size() == 16) begin
      chk("last_win_row", win_r[15], 3);
      chk("last_win_col", win_c[15], 3);
    end
`endif
    step();

    // stall at the first window for 3 cycles
    run_frame(8, 3, 0, 0);
    chk("stall_pixels", pix_seen, 64);
    chk("stall_windows", wins_seen, WIN8);
    step();

    // undersized image is rejected
    start = 1'b1; img_size = LW'(3); in_valid = 1'b1;
    clear_track();
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("small_err", err, 1);
    chk("small_busy", busy, 0);
    chk("small_no_we", pix_seen, 0);
    in_valid = 1'b0;

    // reset in the middle of a frame
    run_frame(8, 0, 0, 20);
    chk("abort_pixels", pix_seen, 20);
    rst = 1'b1;
    reset_model();
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_buf_we", buf_we, 0);
    chk("midrst_win_valid", win_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_buf_sel", buf_sel, 0);
    chk("midrst_buf_addr", buf_addr, 0);
    chk("midrst_buf_top", buf_top, 0);
    step();
    rst = 1'b0;
    step();
    run_frame(8, 0, 0, 0);
    chk("post_rst_pixels", pix_seen, 64);
    chk("post_rst_windows", wins_seen, WIN8);
    step();

    // irregular handshakes on a 9x9 frame, then the minimum 5x5 frame
    run_frame(9, 0, 1, 0);
    chk("gap9_pixels", pix_seen, 81);
    chk("gap9_windows", wins_seen, STRIDE2 ? 9 : 25);
    step();
    run_frame(5, 0, 0, 0);
    chk("min5_windows", wins_seen, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/renkon_ctrl_window.md
RENKON_CTRL_WINDOW -- requirements
Module: renkon_ctrl_window

Interface
REQ-001 FSIZE, 5, filter side length; window is FSIZE x FSIZE.
REQ-002 LWIDTH, 6, width of image-size, row, column and buffer-address fields.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a frame; sampled only in IDLE.
REQ-006 img_size  input  LWIDTH  square image side; latched at accepted start.
REQ-007 in_valid  input  1  upstream pixel valid.
REQ-008 in_ready  output  1  pixel accepted when in_valid && in_ready.
REQ-009 buf_we  output  1  line-buffer write enable, equal to the accept strobe.
REQ-010 buf_sel  output  clog2(FSIZE)  line buffer written this cycle.
REQ-011 buf_addr  output  LWIDTH  column address in the selected line buffer.
REQ-012 buf_top  output  clog2(FSIZE)  index of the oldest line in the current window.
REQ-013 win_valid  output  1  full window present on the line-buffer read side.
REQ-014 win_ready  input  1  downstream consumed the window.
REQ-015 out_row, out_col  output  LWIDTH each  output-plane coordinates of the current window.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the frame ends.
REQ-018 err  output  1  sticky flag; set when start is accepted with img_size < FSIZE; cleared by the next valid start.

Function
REQ-019 FSM: IDLE -> (start, img_size>=FSIZE) PRELOAD; IDLE -> (start, img_size<FSIZE) IDLE with err=1.
REQ-020 PRELOAD: accept rows 0..FSIZE-2; move to STREAM after the last pixel of row FSIZE-2 is accepted.
REQ-021 STREAM: accept the remaining rows; move to DONE after pixel (img_size-1, img_size-1) is accepted and its window is consumed.
REQ-022 DONE: pulse done for one cycle, then go to IDLE; start is ignored in DONE.
REQ-023 Column counter counts 0..img_size-1 and wraps; each wrap increments the row counter and advances buf_sel modulo FSIZE (FSIZE-1 wraps to 0).
REQ-024 buf_addr equals the column counter.
REQ-025 buf_top equals (buf_sel+1) mod FSIZE once row >= FSIZE-1, and 0 before that.
REQ-026 Window position: accepted pixel has row >= FSIZE-1 and col >= FSIZE-1.
REQ-027 win_valid is asserted one cycle after a window-position pixel is accepted and held until win_valid && win_ready.
REQ-028 out_row = row-(FSIZE-1) and out_col = col-(FSIZE-1) for the accepted pixel; both are stable while win_valid is high.
REQ-029 in_ready = busy && state!=DONE && !(win_valid && !win_ready); no pixel is accepted while a window is stalled.
REQ-030 Simultaneous win_ready and accept: the old window retires and the new window is registered in the same cycle; no bubble is inserted.
REQ-031 start while busy is ignored; latched img_size is unchanged.

Reset
REQ-032 rst forces IDLE at any time, including mid-frame.
REQ-033 Counters, buf_sel and buf_top reset to 0; in_ready, buf_we, win_valid, busy, done and err reset to 0.
REQ-034 No pending window survives reset.

Configuration
REQ-035 RENKON_CTRL_WINDOW_STRIDE2_EN defined: windows are flagged only where both out_row and out_col are even; out_row and out_col are reported halved; pixel acceptance is unchanged.
REQ-036 RENKON_CTRL_WINDOW_STRIDE2_EN undefined: stride is 1 and every window position is flagged.

Structure
REQ-037 The FSM state enum (IDLE, PRELOAD, STREAM, DONE) and the default FSIZE and LWIDTH constants live in the shared renkon package.
REQ-038 One sub-module, renkon_wrap_counter (enable, wrap limit, count, wrap pulse), is instantiated for the column counter and the buf_sel ring.

Verification
REQ-039 Bench: reset, then start with img_size=8, FSIZE=5, in_valid=1, win_ready=1 -> first win_valid 1 cycle after pixel 37 (row 4, col 4) is accepted; 16 windows in total; done 1 cycle after the last window.
REQ-040 Bench: hold win_ready=0 for 3 cycles at the first window -> in_ready=0 and out_row/out_col frozen at 0/0; no pixel is lost and all 16 windows are still produced.
REQ-041 Bench: start with img_size=3 -> err=1, busy=0, no buf_we.
REQ-042 Bench: assert rst after 20 pixels -> next cycle IDLE with all outputs 0; a new start with img_size=8 runs a clean frame.
REQ-043 Bench: buf_sel sequence across 8 rows -> 0,1,2,3,4,0,1,2; buf_top=3 during row 7.
REQ-044 Bench: with RENKON_CTRL_WINDOW_STRIDE2_EN, img_size=8 -> 4 windows at out coordinates (0,0), (0,1), (1,0), (1,1).
